count_snapshot_fifo: RTL
========================

Name: count_snapshot_fifo

Overview:
Downstream consumer of the 4-bit up-counter output. It samples the live count on a capture strobe and tags each sample with a wrap epoch, which counts the counter's 15->0 rollovers. Samples are buffered in a small FIFO and presented to a reader over a valid/ready interface. It turns the free-running counter into an ordered, lossless (or overflow-flagged) event log.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >= 2
ADDR_W, 3, log2(DEPTH)
EPOCH_W, 4, width of wrap-epoch counter

Ports:
clock  input  1  rising-edge clock, same domain as counter
reset  input  1  synchronous, active-high
count_in  input  4  live counter value
count_rst  input  1  counter's own reset; qualifies wrap detection
capture  input  1  sample request, one per cycle when high
out_data  output  EPOCH_W+4  {epoch, count} of FIFO head
out_ts  output  16  timestamp of FIFO head (see Optional Feature)
out_valid  output  1  head entry available
out_ready  input  1  reader accepts head
level  output  ADDR_W+1  occupancy, 0..DEPTH
full  output  1  level == DEPTH
empty  output  1  level == 0
overflow  output  1  sticky: capture dropped
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (sync, active-high) clears prev_count to 0, epoch to 0, read and write pointers to 0, level to 0 and overflow to 0. out_valid=0, empty=1, full=0. out_data is don't-care while out_valid=0. Reset mid-operation discards all stored entries.
- Wrap detect: prev_count <= count_in every cycle. wrap = (prev_count==4'hF) && (count_in==4'h0) && !count_rst.
- Epoch: count_rst=1 -> epoch <= 0 (priority). Else wrap=1 -> epoch <= epoch+1, mod 2^EPOCH_W, silent rollover.
- Entry value: {epoch_next, count_in}, where epoch_next is the epoch value after this cycle's wrap/clear is applied. A capture in the same cycle as a wrap therefore carries the incremented epoch.
- FIFO is first-word-fall-through:
  - out_valid = !empty; out_data = mem[rd_ptr].
  - pop = out_valid && out_ready. A pop advances rd_ptr at the clock edge.
- Push rules: push = capture && (!full || pop).
  - Full with simultaneous pop: push and pop both occur; level unchanged.
  - Empty with capture: entry written; out_valid=1 the next cycle (1-cycle latency). out_ready is ignored while out_valid=0.
- Overflow: capture && full && !pop -> sample dropped, overflow <= 1. If ovf_clr and a new drop occur in the same cycle, the set wins. Otherwise ovf_clr=1 -> overflow <= 0.
- Level: +1 on push-only, -1 on pop-only, unchanged on both or neither. full and empty derive from level and are registered-consistent with the pointers.
- Pointers: ADDR_W bits, wrap naturally at DEPTH.
- count_in is sampled as presented; no synchroniser, same clock domain.

Optional Feature:
Macro SNAP_TIMESTAMP_EN.
- Defined: a 16-bit free-running cycle counter (reset 0, +1 every cycle, wraps at 16'hFFFF->0) is stored alongside each entry. out_ts shows the head entry's capture-cycle timestamp.
- Undefined: no timestamp counter or storage; out_ts tied to 16'h0000.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then capture with count_in=4'h5, epoch 0 -> next cycle out_valid=1, out_data={4'h0,4'h5}, level=1. Assert out_ready -> empty=1 the following cycle.
- count_in steps 4'hE,4'hF,4'h0 with capture on the 4'h0 cycle -> out_data={4'h1,4'h0}. Repeat the same sequence with count_rst=1 on the 4'h0 cycle -> epoch 0, out_data={4'h0,4'h0}.
- Hold out_ready=0 and capture 9 times with count_in=1..9, DEPTH=8 -> full=1, level=8, overflow=1. Drain yields 1..8 in order; 9 lost. Then ovf_clr=1 -> overflow=0.
- Full FIFO, capture and out_ready both high for 3 cycles -> level stays 8, overflow stays 0. Output order is preserved: oldest 3 popped, 3 new appended.
- Reset asserted with level=5 -> next cycle level=0, out_valid=0, epoch=0, overflow=0.
- With SNAP_TIMESTAMP_EN defined, capture at cycle 10 and cycle 25 after reset -> out_ts=16'd10 then 16'd25. Undefined -> out_ts=0 for both.

Source files
------------

// File: rtl/count_snapshot_fifo_if.sv
// Reader-side port bundle for count_snapshot_fifo: head entry, optional timestamp, valid/ready.
interface count_snapshot_fifo_if #(
  parameter int EPOCH_W = 4
);
  logic [EPOCH_W+3:0] out_data;
  logic [15:0]        out_ts;
  logic               out_valid;
  logic               out_ready;

  modport master (output out_data, output out_ts, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ts, input out_valid, output out_ready);
endinterface

// File: rtl/count_snapshot_fifo.sv
// Captures {wrap epoch, count} samples into a first-word-fall-through FIFO; head visible 1 cycle after push,
// capture into a full FIFO with no pop is dropped and sets sticky overflow. SNAP_TIMESTAMP_EN adds a 16-bit capture timestamp.
module count_snapshot_fifo #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int EPOCH_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          count_in,
  input  logic                count_rst,
  input  logic                capture,
  output logic [ADDR_W:0]     level,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  input  logic                ovf_clr,
  count_snapshot_fifo_if.master rd
);

  logic [3:0]           prev_count;
  logic [EPOCH_W-1:0]   epoch;
  logic [EPOCH_W-1:0]   epoch_next;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [EPOCH_W+3:0]   mem [DEPTH];
  logic                 wrap;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign wrap = (prev_count == 4'hF) && (count_in == 4'h0) && !count_rst;

  // Counter reset dominates a coincident wrap.
  always_comb begin
    epoch_next = epoch;
    if (count_rst)
      epoch_next = '0;
    else if (wrap)
      epoch_next = epoch + 1'b1;
  end

  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);
  assign pop   = rd.out_valid && rd.out_ready;
  assign push  = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  assign rd.out_valid = !empty;
  assign rd.out_data  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_count <= '0;
      epoch      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_count <= count_in;
      epoch      <= epoch_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      // A fresh drop outranks a clear in the same cycle.
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= {epoch_next, count_in};
  end

`ifdef SNAP_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_cnt + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (push)
      ts_mem[wr_ptr] <= ts_cnt;
  end

  assign rd.out_ts = ts_mem[rd_ptr];
`else
  assign rd.out_ts = 16'h0000;
`endif

endmodule
